// File: rtl/xor_backprop.sv
// Backpropagation trainer for a 2-2-1 XOR network: sign-magnitude Q8.8, 9-entry weight file.
// Define BP_SATURATE_EN to clamp overflowing weight updates; by default they wrap to 16 bits.
module xor_backprop #(
  parameter int unsigned LR_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [16:0] x1,
  input  logic [16:0] x2,
  input  logic [16:0] h1,
  input  logic [16:0] h2,
  input  logic [16:0] y,
  input  logic [16:0] target,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [16:0] wr_data,
  input  logic [3:0]  rd_addr,
  output logic [16:0] rd_data,
  output logic        busy,
  output logic        done
);

  localparam logic [16:0] ONE = 17'h00100;

  typedef enum logic [2:0] {S_IDLE, S_CAP, S_ERR, S_DOUT, S_DHID, S_UPD} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [16:0] r_w [0:8];
  logic [16:0] r_x1, r_x2, r_h1, r_h2, r_y, r_t;
  logic [16:0] r_err, r_om, r_yd, r_do, r_om1, r_om2;
  logic [16:0] r_hh1, r_hh2, r_t1, r_t2, r_dh1, r_dh2;

  logic [16:0] w_d, w_in, w_prod, w_step, w_cur, w_new;
  logic [15:0] w_step_mag, w_mag;
  logic [17:0] w_sum;

  function automatic logic [16:0] sm_mul(input logic [16:0] a, input logic [16:0] b);
    logic [31:0] p;
    logic [15:0] m;
    p = ({16'd0, a[15:0]} * {16'd0, b[15:0]}) >> 8;
    m = (|p[31:16]) ? 16'hFFFF : p[15:0];
    return {(a[16] ^ b[16]) & (|m), m};
  endfunction

  // Result is {sign, 17-bit magnitude} so callers choose saturate or wrap.
  function automatic logic [17:0] sm_add(input logic [16:0] a, input logic [16:0] b);
    logic [16:0] s;
    logic        sg;
    if (a[16] == b[16]) begin
      s  = {1'b0, a[15:0]} + {1'b0, b[15:0]};
      sg = a[16];
    end else if (a[15:0] >= b[15:0]) begin
      s  = {1'b0, a[15:0] - b[15:0]};
      sg = a[16];
    end else begin
      s  = {1'b0, b[15:0] - a[15:0]};
      sg = b[16];
    end
    return {sg & (|s), s};
  endfunction

  // Intermediate differences (err, 1-y, 1-h) always saturate.
  function automatic logic [16:0] sm_sub(input logic [16:0] a, input logic [16:0] b);
    logic [17:0] r;
    r = sm_add(a, {~b[16] & (|b[15:0]), b[15:0]});
    return r[16] ? {r[17], 16'hFFFF} : {r[17], r[15:0]};
  endfunction

  always_comb begin
    w_d  = r_do;
    w_in = ONE;
    case (r_cnt)
      4'd0: begin w_d = r_dh1; w_in = r_x1; end
      4'd1: begin w_d = r_dh1; w_in = r_x2; end
      4'd2: begin w_d = r_dh2; w_in = r_x1; end
      4'd3: begin w_d = r_dh2; w_in = r_x2; end
      4'd4: begin w_d = r_do;  w_in = r_h1; end
      4'd5: begin w_d = r_do;  w_in = r_h2; end
      4'd6: begin w_d = r_dh1; w_in = ONE;  end
      4'd7: begin w_d = r_dh2; w_in = ONE;  end
      default: begin w_d = r_do; w_in = ONE; end
    endcase
    w_prod     = sm_mul(w_d, w_in);
    w_step_mag = w_prod[15:0] >> LR_SHIFT;
    w_step     = {w_prod[16] & (|w_step_mag), w_step_mag};
    w_cur      = (r_cnt <= 4'd8) ? r_w[r_cnt] : '0;
    w_sum      = sm_add(w_cur, w_step);
`ifdef BP_SATURATE_EN
    w_mag      = w_sum[16] ? 16'hFFFF : w_sum[15:0];
`else
    w_mag      = w_sum[15:0];
`endif
    w_new      = {w_sum[17] & (|w_mag), w_mag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= '0;
      r_w[0]  <= 17'h000AB;
      r_w[1]  <= 17'h000AB;
      r_w[2]  <= 17'h100AB;
      r_w[3]  <= 17'h100AB;
      r_w[4]  <= 17'h000AB;
      r_w[5]  <= 17'h000AB;
      r_w[6]  <= 17'h10500;
      r_w[7]  <= 17'h01000;
      r_w[8]  <= 17'h11000;
      r_x1 <= '0; r_x2 <= '0; r_h1 <= '0; r_h2 <= '0; r_y <= '0; r_t <= '0;
      r_err <= '0; r_om <= '0; r_yd <= '0; r_do <= '0; r_om1 <= '0; r_om2 <= '0;
      r_hh1 <= '0; r_hh2 <= '0; r_t1 <= '0; r_t2 <= '0; r_dh1 <= '0; r_dh2 <= '0;
    end else begin
      done    <= 1'b0;
      rd_data <= (rd_addr <= 4'd8) ? r_w[rd_addr] : '0;
      case (r_state)
        S_IDLE: begin
          if (wr_en && (wr_addr <= 4'd8)) r_w[wr_addr] <= wr_data;
          if (start) begin
            r_state <= S_CAP;
            busy    <= 1'b1;
            r_x1 <= x1; r_x2 <= x2; r_h1 <= h1; r_h2 <= h2; r_y <= y; r_t <= target;
          end
        end
        S_CAP: begin
          r_err   <= sm_sub(r_t, r_y);
          r_om    <= sm_sub(ONE, r_y);
          r_state <= S_ERR;
        end
        S_ERR: begin
          r_yd    <= sm_mul(r_y, r_om);
          r_cnt   <= '0;
          r_state <= S_DOUT;
        end
        S_DOUT: begin
          if (r_cnt == 4'd0) begin
            r_do  <= sm_mul(r_err, r_yd);
            r_cnt <= 4'd1;
          end else begin
            r_om1   <= sm_sub(ONE, r_h1);
            r_om2   <= sm_sub(ONE, r_h2);
            r_cnt   <= '0;
            r_state <= S_DHID;
          end
        end
        S_DHID: begin
          if (r_cnt == 4'd0) begin
            r_hh1 <= sm_mul(r_h1, r_om1);
            r_hh2 <= sm_mul(r_h2, r_om2);
            r_t1  <= sm_mul(r_do, r_w[4]);
            r_t2  <= sm_mul(r_do, r_w[5]);
          end else if (r_cnt == 4'd1) begin
            r_dh1 <= sm_mul(r_t1, r_hh1);
            r_dh2 <= sm_mul(r_t2, r_hh2);
          end
          if (r_cnt == 4'd5) begin
            r_cnt   <= '0;
            r_state <= S_UPD;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_UPD: begin
          r_w[r_cnt] <= w_new;
          if (r_cnt == 4'd8) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
